// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard / forwarding unit.
package hazard_pkg;

  // EX operand mux select: where the operand value comes from.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

  // Wide enough for any MDU latency up to 15 cycles.
  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of the hazard / forwarding unit.
// The slave modport is the unit itself; the master modport is the pipeline.
interface hazard_fwd_unit_if #(
  parameter int AW     = 5,
  parameter int NPORTS = 2,
  parameter int CNT_W  = 32
);
  logic [NPORTS*AW-1:0] id_src;
  logic [NPORTS-1:0]    id_src_used;
  logic [AW-1:0]        id_rd;
  logic                 id_mdu_op;
  logic [NPORTS*AW-1:0] ex_src;
  logic                 ex_mem_read;
  logic [AW-1:0]        ex_rd;
  logic                 ex_mdu_op;
  logic                 exmem_reg_write;
  logic [AW-1:0]        exmem_rd;
  logic                 memwb_reg_write;
  logic [AW-1:0]        memwb_rd;
  logic [2*NPORTS-1:0]  fwd_sel;
  logic                 stall;
  logic                 bubble;
  logic                 mdu_busy;
  logic                 mdu_wb;
  logic [AW-1:0]        mdu_wb_rd;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_src, id_src_used, id_rd, id_mdu_op,
    output ex_src, ex_mem_read, ex_rd, ex_mdu_op,
    output exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
    input  fwd_sel, stall, bubble, mdu_busy, mdu_wb, mdu_wb_rd, stall_cnt
  );

  modport slave (
    input  id_src, id_src_used, id_rd, id_mdu_op,
    input  ex_src, ex_mem_read, ex_rd, ex_mdu_op,
    input  exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
    output fwd_sel, stall, bubble, mdu_busy, mdu_wb, mdu_wb_rd, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit_fwd_lane.sv
// One EX operand forwarding lane: compares the operand index against the
// EX/MEM and MEM/WB destinations; the younger EX/MEM result wins.
module fwd_lane
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] ex_src,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  output fwd_sel_t      sel
);

  // Priority encode the forwarding source; r0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard unit: per-port EX forward selects, load-use and
// MDU stalls, a single in-flight MDU scoreboard and a stall-cycle counter.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int NPORTS  = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input logic            clk,
  input logic            rst_n,
  hazard_fwd_unit_if.slave bus
);

  localparam logic [MDU_CNT_W-1:0] LAT = MDU_CNT_W'(MDU_LAT);

  logic [MDU_CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]        mdu_rd_q, mdu_rd_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [2*NPORTS-1:0]  fwd_sel_w;
  logic [AW-1:0]        src;
  logic                 mdu_busy;
  logic                 load_use;
  logic                 mdu_raw;
  logic                 mdu_waw;
  logic                 mdu_struct;
  logic                 stall;

  for (genvar p = 0; p < NPORTS; p++) begin : g_lane
    fwd_sel_t sel;
    fwd_lane #(.AW(AW)) u_lane (
      .ex_src          (bus.ex_src[p*AW +: AW]),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_rd        (bus.exmem_rd),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_rd        (bus.memwb_rd),
      .sel             (sel)
    );
    assign fwd_sel_w[2*p +: 2] = sel;
  end

  assign mdu_busy = (count_q != '0);

  // OR together every reason the ID instruction must wait.
  always_comb begin
    load_use = 1'b0;
    mdu_raw  = 1'b0;
    src      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      src = bus.id_src[p*AW +: AW];
      if (bus.id_src_used[p] && (src != '0)) begin
        if (bus.ex_mem_read && (bus.ex_rd != '0) && (bus.ex_rd == src)) begin
          load_use = 1'b1;
        end
        if (mdu_busy && (mdu_rd_q == src)) begin
          mdu_raw = 1'b1;
        end
      end
    end
    mdu_waw    = mdu_busy && (bus.id_rd != '0) && (bus.id_rd == mdu_rd_q);
    mdu_struct = bus.id_mdu_op && (count_q > MDU_CNT_W'(1));
    stall      = load_use | mdu_raw | mdu_waw | mdu_struct;
  end

  // MDU latency countdown; an issue always reloads, even on the final cycle.
  always_comb begin
    count_d  = count_q;
    mdu_rd_d = mdu_rd_q;
    if (bus.ex_mdu_op) begin
      count_d  = LAT;
      mdu_rd_d = bus.ex_rd;
    end else if (count_q != '0) begin
      count_d = count_q - MDU_CNT_W'(1);
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Scoreboard and counter state; reset aborts any MDU op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      mdu_rd_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      count_q     <= count_d;
      mdu_rd_q    <= mdu_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A second issue while the first still has two or more cycles left means
  // the structural stall was bypassed; the old op would be silently lost.
  a_no_overlap_issue : assert property (
    @(posedge clk) disable iff (!rst_n) bus.ex_mdu_op |-> (count_q < MDU_CNT_W'(2))
  );

  assign bus.fwd_sel   = fwd_sel_w;
  assign bus.stall     = stall;
  assign bus.bubble    = stall;
  assign bus.mdu_busy  = mdu_busy;
  assign bus.mdu_wb    = (count_q == MDU_CNT_W'(1)) && (mdu_rd_q != '0);
  assign bus.mdu_wb_rd = mdu_rd_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit (MDU_LAT = 4, 4-bit stall counter
// so that saturation is reachable in a short run).
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

  localparam int AW      = 5;
  localparam int NPORTS  = 2;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   wb_pulses;
  int   wb_first;
  int   wb_second;

  hazard_fwd_unit_if #(.AW(AW), .NPORTS(NPORTS), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(
    .AW(AW), .NPORTS(NPORTS), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic [9:0] id_src, input logic [1:0] id_used, input logic [4:0] id_rd,
    input logic id_mdu, input logic [9:0] ex_src, input logic ex_mem_read,
    input logic [4:0] ex_rd, input logic ex_mdu, input logic exmem_we,
    input logic [4:0] exmem_rd, input logic memwb_we, input logic [4:0] memwb_rd);
    bus.id_src          = id_src;
    bus.id_src_used     = id_used;
    bus.id_rd           = id_rd;
    bus.id_mdu_op       = id_mdu;
    bus.ex_src          = ex_src;
    bus.ex_mem_read     = ex_mem_read;
    bus.ex_rd           = ex_rd;
    bus.ex_mdu_op       = ex_mdu;
    bus.exmem_reg_write = exmem_we;
    bus.exmem_rd        = exmem_rd;
    bus.memwb_reg_write = memwb_we;
    bus.memwb_rd        = memwb_rd;
    #1;
  endtask

  task automatic idle();
    applyStimulus('0, '0, '0, 0, '0, 0, '0, 0, 0, '0, 0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic recordWb(input int c);
    if (bus.mdu_wb) begin
      wb_pulses++;
      if (wb_first < 0) wb_first = c;
      else wb_second = c;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();

    // Reset state
    checkOutput("rst_fwd_sel", 32'(bus.fwd_sel), 0);
    checkOutput("rst_stall", 32'(bus.stall), 0);
    checkOutput("rst_bubble", 32'(bus.bubble), 0);
    checkOutput("rst_mdu_busy", 32'(bus.mdu_busy), 0);
    checkOutput("rst_mdu_wb", 32'(bus.mdu_wb), 0);
    checkOutput("rst_mdu_wb_rd", 32'(bus.mdu_wb_rd), 0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Forwarding priority and r0 handling
    applyStimulus('0, '0, '0, 0, {5'd0, 5'd7}, 0, '0, 0, 1, 5'd7, 1, 5'd7);
    checkOutput("fwd_exmem_wins", 32'(bus.fwd_sel), 32'b0010);
    applyStimulus('0, '0, '0, 0, {5'd0, 5'd7}, 0, '0, 0, 0, 5'd7, 1, 5'd7);
    checkOutput("fwd_memwb_only", 32'(bus.fwd_sel), 32'b0001);
    applyStimulus('0, '0, '0, 0, {5'd0, 5'd0}, 0, '0, 0, 1, 5'd0, 0, 5'd0);
    checkOutput("fwd_r0_never", 32'(bus.fwd_sel), 32'b0000);
    applyStimulus('0, '0, '0, 0, {5'd7, 5'd3}, 0, '0, 0, 1, 5'd3, 1, 5'd7);
    checkOutput("fwd_mixed_ports", 32'(bus.fwd_sel), 32'b0110);
    applyStimulus('0, '0, '0, 0, {5'd4, 5'd4}, 0, '0, 0, 1, 5'd3, 1, 5'd7);
    checkOutput("fwd_no_match", 32'(bus.fwd_sel), 32'b0000);
    checkOutput("fwd_no_stall", 32'(bus.stall), 0);

    // Load-use stall on port 1
    applyStimulus({5'd5, 5'd0}, 2'b10, '0, 0, '0, 1, 5'd5, 0, 0, '0, 0, '0);
    checkOutput("lu_stall", 32'(bus.stall), 1);
    checkOutput("lu_bubble", 32'(bus.bubble), 1);
    checkOutput("lu_cnt_before", 32'(bus.stall_cnt), 0);
    tick();
    applyStimulus({5'd5, 5'd0}, 2'b10, '0, 0, '0, 0, '0, 0, 0, '0, 0, '0);
    checkOutput("lu_released", 32'(bus.stall), 0);
    checkOutput("lu_cnt_after", 32'(bus.stall_cnt), 1);
    applyStimulus({5'd5, 5'd0}, 2'b00, '0, 0, '0, 1, 5'd5, 0, 0, '0, 0, '0);
    checkOutput("lu_port_unused", 32'(bus.stall), 0);
    applyStimulus({5'd0, 5'd5}, 2'b01, '0, 0, '0, 1, 5'd5, 0, 0, '0, 0, '0);
    checkOutput("lu_port0", 32'(bus.stall), 1);

    // MDU RAW: issue r9, dependent reader in ID
    applyStimulus('0, '0, '0, 0, '0, 0, 5'd9, 1, 0, '0, 0, '0);
    checkOutput("mdu_idle_before", 32'(bus.mdu_busy), 0);
    tick();
    for (int k = 1; k <= MDU_LAT; k++) begin
      applyStimulus({5'd0, 5'd9}, 2'b01, '0, 0, '0, 0, '0, 0, 0, '0, 0, '0);
      checkOutput($sformatf("raw_stall_%0d", k), 32'(bus.stall), 1);
      checkOutput($sformatf("raw_busy_%0d", k), 32'(bus.mdu_busy), 1);
      checkOutput($sformatf("raw_wb_%0d", k), 32'(bus.mdu_wb), (k == MDU_LAT) ? 1 : 0);
      if (k == MDU_LAT) checkOutput("raw_wb_rd", 32'(bus.mdu_wb_rd), 9);
      tick();
    end
    applyStimulus({5'd0, 5'd9}, 2'b01, '0, 0, '0, 0, '0, 0, 0, '0, 0, '0);
    checkOutput("raw_released", 32'(bus.stall), 0);
    checkOutput("raw_busy_done", 32'(bus.mdu_busy), 0);
    checkOutput("raw_cnt", 32'(bus.stall_cnt), 5);

    // Back-to-back MDU ops: r10 then r11, plus a WAW check on r11
    wb_pulses = 0;
    wb_first  = -1;
    wb_second = -1;
    applyStimulus('0, '0, '0, 0, '0, 0, 5'd10, 1, 0, '0, 0, '0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus('0, '0, 5'd11, 1, '0, 0, '0, 0, 0, '0, 0, '0);
      checkOutput($sformatf("b2b_struct_%0d", c), 32'(bus.stall), 1);
      recordWb(c);
      tick();
    end
    applyStimulus('0, '0, '0, 0, '0, 0, 5'd11, 1, 0, '0, 0, '0);
    checkOutput("b2b_issue_nostall", 32'(bus.stall), 0);
    checkOutput("b2b_wb1", 32'(bus.mdu_wb), 1);
    checkOutput("b2b_wb1_rd", 32'(bus.mdu_wb_rd), 10);
    recordWb(4);
    tick();
    applyStimulus('0, '0, 5'd11, 0, '0, 0, '0, 0, 0, '0, 0, '0);
    checkOutput("waw_stall", 32'(bus.stall), 1);
    recordWb(5);
    tick();
    for (int c = 6; c <= 9; c++) begin
      idle();
      recordWb(c);
      if (c == 8) checkOutput("b2b_wb2_rd", 32'(bus.mdu_wb_rd), 11);
      if (c < 9) tick();
    end
    checkOutput("b2b_wb_pulses", 32'(wb_pulses), 2);
    checkOutput("b2b_wb_spacing", 32'(wb_second - wb_first), MDU_LAT);
    checkOutput("b2b_busy_done", 32'(bus.mdu_busy), 0);
    checkOutput("b2b_cnt", 32'(bus.stall_cnt), 9);

    // Asynchronous reset while count_q = 2
    applyStimulus('0, '0, '0, 0, '0, 0, 5'd12, 1, 0, '0, 0, '0);
    tick();
    idle();
    tick();
    tick();
    applyStimulus({5'd0, 5'd12}, 2'b01, '0, 0, '0, 0, '0, 0, 0, '0, 0, '0);
    checkOutput("pre_reset_stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.mdu_busy), 0);
    checkOutput("midrst_wb", 32'(bus.mdu_wb), 0);
    checkOutput("midrst_wb_rd", 32'(bus.mdu_wb_rd), 0);
    checkOutput("midrst_stall", 32'(bus.stall), 0);
    checkOutput("midrst_cnt", 32'(bus.stall_cnt), 0);
    idle();
    tick();
    rst_n = 1'b1;
    wb_pulses = 0;
    wb_first  = -1;
    wb_second = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      recordWb(c);
    end
    checkOutput("post_rst_no_wb", 32'(wb_pulses), 0);

    // Stall counter saturation (4-bit counter)
    applyStimulus({5'd5, 5'd0}, 2'b10, '0, 0, '0, 1, 5'd5, 0, 0, '0, 0, '0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) checkOutput("sat_cnt_14", 32'(bus.stall_cnt), 14);
      if (i == 15) checkOutput("sat_cnt_15", 32'(bus.stall_cnt), 15);
    end
    checkOutput("sat_cnt_held", 32'(bus.stall_cnt), 15);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline, generalising the two-operand EX-stage forwarding logic. Per read port it produces EX-stage forward selects. It detects load-use hazards in ID and stalls for them. It also tracks one in-flight multi-cycle multiply/divide (MDU) operation with a latency counter and scoreboard register, and emits its writeback strobe. It sits beside the ID/EX register and drives PC/IF-ID hold, ID/EX bubble and the EX operand muxes.

## Interface
Parameters:
- AW, 5, register-index width
- NPORTS, 2, number of operand read ports (rs, rt, optional third source)
- MDU_LAT, 4, MDU cycles from issue to writeback; legal range 2..15
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_src  in  NPORTS*AW  operand indices of the instruction in ID; port p = bits [p*AW +: AW]
- id_src_used  in  NPORTS  port p actually reads a register
- id_rd  in  AW  ID destination register; 0 = none
- id_mdu_op  in  1  ID instruction is an MDU op
- ex_src  in  NPORTS*AW  operand indices in ID/EX
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_rd  in  AW  ID/EX destination register
- ex_mdu_op  in  1  ID/EX instruction is an MDU op (0 for bubbles)
- exmem_reg_write  in  1  EX/MEM writes the register file
- exmem_rd  in  AW  EX/MEM destination register
- memwb_reg_write  in  1  MEM/WB writes the register file
- memwb_rd  in  AW  MEM/WB destination register
- fwd_sel  out  2*NPORTS  per-port select: 00 regfile, 10 EX/MEM, 01 MEM/WB (11 unused)
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  load zeros into ID/EX control this cycle (equals stall)
- mdu_busy  out  1  MDU operation in flight
- mdu_wb  out  1  MDU result writes the register file this cycle
- mdu_wb_rd  out  AW  destination register for mdu_wb
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
Forwarding (combinational, per port p):
- Select EX/MEM (10) if exmem_reg_write, exmem_rd != 0 and exmem_rd == ex_src[p].
- Otherwise select MEM/WB (01) if memwb_reg_write, memwb_rd != 0 and memwb_rd == ex_src[p].
- Otherwise select regfile (00).
- EX/MEM always wins when both stages match.

Stall sources (combinational, OR-ed into stall). Only ports with id_src_used[p] = 1 and id_src[p] != 0 participate.
- Load-use: ex_mem_read, ex_rd != 0 and ex_rd matches an active ID port.
- MDU RAW: mdu_busy and mdu_rd_q matches an active ID port.
- MDU WAW: mdu_busy, id_rd != 0 and id_rd == mdu_rd_q.
- MDU structural: id_mdu_op and count_q >= 2.

MDU scoreboard:
- State is IDLE (count_q = 0) or BUSY (count_q = 1..MDU_LAT).
- Issue: ex_mdu_op in IDLE, or in BUSY with count_q = 1, loads count_q = MDU_LAT and captures mdu_rd_q = ex_rd.
- BUSY decrements count_q every cycle.
- mdu_busy = (count_q != 0).
- mdu_wb = (count_q == 1) and mdu_rd_q != 0; mdu_wb_rd = mdu_rd_q.
- Issue with count_q >= 2 cannot occur under correct stalling. If it does, the new issue overwrites the old one; this is flagged by a simulation-only assertion.

stall_cnt: increments on every cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset values: count_q = 0, mdu_rd_q = 0, stall_cnt = 0. Consequently fwd_sel = 0, stall = bubble = 0, mdu_busy = 0, mdu_wb = 0, mdu_wb_rd = 0.
- fwd_sel, stall and bubble are same-cycle combinational; mdu_* outputs are derived from registers only.
- Issue at edge t gives mdu_busy high for cycles t+1..t+MDU_LAT and mdu_wb high in cycle t+MDU_LAT only.
- A dependent ID instruction stalls through cycle t+MDU_LAT and proceeds in t+MDU_LAT+1, when it reads the written regfile.
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_read.
- Back-to-back MDU ops: the second reaches EX in the cycle count_q = 1, so writeback and issue coincide. The new count loads and no cycle is lost.
- Asynchronous reset mid-operation aborts the MDU op; no mdu_wb is emitted.

## Structure
- Package hazard_pkg holds the FWD_RF, FWD_EXMEM and FWD_MEMWB select constants and the fwd_sel_t typedef.
- Sub-module fwd_lane is one per-port comparator/priority encoder, instantiated NPORTS times by generate.
- The scoreboard, stall OR-tree and counter live in the top level.

## Test plan
- exmem_rd = memwb_rd = 7, both write enables set, ex_src[0] = 7 -> fwd_sel[1:0] = 10. Clear exmem_reg_write -> 01.
- exmem_rd = 0 with write enable set, ex_src[1] = 0 -> fwd_sel[3:2] = 00.
- ex_mem_read, ex_rd = 5, id_src[1] = 5 used -> stall = bubble = 1 for one cycle, stall_cnt 0 -> 1. The same case with id_src_used[1] = 0 -> no stall.
- MDU issue with ex_rd = 9 at t (MDU_LAT = 4); ID reads r9 -> stall for cycles t+1..t+4, mdu_wb with mdu_wb_rd = 9 at t+4, stall = 0 at t+5.
- Two MDU ops back-to-back -> the second stalls until count_q = 1, then issues. mdu_wb pulses exactly twice, MDU_LAT cycles apart.
- rst_n low while count_q = 2 -> all outputs 0 immediately; no mdu_wb after release. Force stall_cnt near max -> it saturates at all-ones.
